// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard, redirect and data-memory stall controller
//
// Purpose:
//   Drives the enable and bubble-insert controls of the PC, IF/ID, ID/EX,
//   EX/MEM and MEM/WB registers of a 5-stage pipeline. It arbitrates between
//   a data-memory freeze, a taken redirect resolved in MEM and an ID/EX
//   load-use hazard, and keeps saturating stall/flush event counters plus a
//   sticky memory-timeout error.
//
// Parameters:
//   MEM_TIMEOUT  consecutive WAIT cycles tolerated on one access before mem_err
//   CNT_W        width of stall_cnt / flush_cnt
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   IDrs, IDrt, IDusesRt       source fields of the instruction in ID
//   EXm2reg, EXwn              load flag / destination of the instruction in EX
//   MEMm2reg, MEMwmem          load / store flags of the instruction in MEM
//   MEMjumpType, MEMzero       redirect type (0 none,1 beq,2 bne,3 jump), zero flag
//   dmem_ready                 data memory completes the access this cycle
//   dmem_req                   data-memory request
//   pc_en, pc_sel_jump         PC load enable, PC source select
//   ifid_en/flush, idex_en/flush, exmem_en/flush, memwb_flush
//                              pipeline register enables / bubble inserts
//   mem_err                    sticky timeout error
//   stall_cnt, flush_cnt       saturating event counters

module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IDrs,
  input  logic [4:0]       IDrt,
  input  logic             IDusesRt,
  input  logic             EXm2reg,
  input  logic [4:0]       EXwn,
  input  logic             MEMm2reg,
  input  logic             MEMwmem,
  input  logic [1:0]       MEMjumpType,
  input  logic             MEMzero,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             pc_sel_jump,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [WCNT_W-1:0] wait_inc;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic memop;
  logic freeze;
  logic taken;
  logic loaduse;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign memop = MEMm2reg | MEMwmem;

  // ERR keeps the pipe frozen regardless of what sits in MEM.
  assign freeze = (state_q == S_ERR) | (memop & ~dmem_ready);

  always_comb begin
    taken = 1'b0;
    case (MEMjumpType)
      2'd1:    taken = MEMzero;
      2'd2:    taken = ~MEMzero;
      2'd3:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // $0 is never a real producer, so a load into $0 cannot create a hazard.
  assign loaduse = EXm2reg & (EXwn != 5'd0) &
                   ((EXwn == IDrs) | (IDusesRt & (EXwn == IDrt)));

  // ---------------------------------------------------------------------------
  // Pipeline control outputs (freeze > taken > loaduse > normal)
  // ---------------------------------------------------------------------------
  always_comb begin
    dmem_req    = 1'b0;
    pc_en       = 1'b0;
    pc_sel_jump = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;

    if (!rst) begin
      dmem_req = memop & (state_q != S_ERR);

      if (freeze) begin
        // Hold every stage; MEM/WB takes a bubble so WB does not retire
        // the stalled MEM instruction twice. A pending redirect waits.
        memwb_flush = 1'b1;
      end else if (taken) begin
        // Redirect; the three younger instructions in IF/ID/EX are squashed.
        pc_en       = 1'b1;
        pc_sel_jump = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b1;
        idex_en     = 1'b1;
        idex_flush  = 1'b1;
        exmem_en    = 1'b1;
        exmem_flush = 1'b1;
      end else if (loaduse) begin
        // Hold PC and IF/ID, push a bubble into EX while the load advances.
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory-wait FSM
  // ---------------------------------------------------------------------------
  assign wait_inc = wait_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;

    case (state_q)
      S_RUN: begin
        wait_cnt_d = '0;
        if (memop && !dmem_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // Ready on the very cycle the count would hit the limit still wins.
        if (!memop || dmem_ready) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else if (wait_inc == WCNT_W'(MEM_TIMEOUT)) begin
          state_d    = S_ERR;
          wait_cnt_d = wait_inc;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end

      S_ERR: begin
        // Only reset leaves ERR.
        state_d = S_ERR;
      end

      default: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Saturating event counters
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // A redirect is only an event when it is actually acted on.
    if (taken && !freeze && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
